// File: rtl/axis_uart_tx_arbiter_if.sv
// AXI-Stream byte bundle between N_SRC byte sources, the TX arbiter and the UART TX sink.
// slave is the arbiter's view; master is the view of whoever drives the sources and the sink.
interface axis_uart_tx_arbiter_if #(
    parameter int unsigned N_SRC = 4
);
    logic [N_SRC*8-1:0] s_tdata_i;
    logic [N_SRC-1:0]   s_tvalid_i;
    logic [N_SRC-1:0]   s_tlast_i;
    logic [N_SRC-1:0]   s_tready_o;
    logic [7:0]         m_tdata_o;
    logic               m_tvalid_o;
    logic               m_tready_i;

    modport slave (
        input  s_tdata_i,
        input  s_tvalid_i,
        input  s_tlast_i,
        input  m_tready_i,
        output s_tready_o,
        output m_tdata_o,
        output m_tvalid_o
    );

    modport master (
        output s_tdata_i,
        output s_tvalid_i,
        output s_tlast_i,
        output m_tready_i,
        input  s_tready_o,
        input  m_tdata_o,
        input  m_tvalid_o
    );
endinterface

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART TX byte stream from N_SRC AXIS sources.
// Optional UART_ARB_SRC_HDR_EN: prefix every grant with header byte 8'hA0 | winner index.
module axis_uart_tx_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axis_uart_tx_arbiter_if.slave        axis,
    input  logic [N_SRC-1:0]             src_mask_i,
    output logic [N_SRC-1:0]             grant_o,
    output logic                         busy_o
);
    localparam int unsigned IdxW     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [7:0]  LastBeat = 8'(MAX_BEATS - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_SRC - 1);

`ifdef UART_ARB_SRC_HDR_EN
    typedef enum logic [1:0] {StIdle, StHdr, StPass} state_e;
`else
    typedef enum logic [0:0] {StIdle, StPass} state_e;
`endif

    state_e            state_q, state_d;
    logic [IdxW-1:0]   gidx_q, gidx_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0]  grant_q, grant_d;
    logic [7:0]        beat_ct_q, beat_ct_d;

    logic [N_SRC-1:0]  req;
    logic              found;
    logic [IdxW-1:0]   winner;
    logic [IdxW-1:0]   cand;
    logic [7:0]        g_tdata;
    logic              g_tvalid;
    logic              g_tlast;
    logic              beat;

    // Scan starts one past the last owner, so the previous owner is considered last.
    always_comb begin
        req    = axis.s_tvalid_i & src_mask_i;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= N_SRC; i++) begin
            cand = IdxW'((32'(rr_ptr_q) + i) % N_SRC);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign g_tdata  = axis.s_tdata_i[{gidx_q, 3'b000} +: 8];
    assign g_tvalid = axis.s_tvalid_i[gidx_q];
    assign g_tlast  = axis.s_tlast_i[gidx_q];

    always_comb begin
        state_d         = state_q;
        gidx_d          = gidx_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        beat_ct_d       = beat_ct_q;
        beat            = 1'b0;
        axis.s_tready_o = '0;
        axis.m_tdata_o  = '0;
        axis.m_tvalid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gidx_d    = winner;
                    grant_d   = N_SRC'(1) << winner;
                    beat_ct_d = '0;
`ifdef UART_ARB_SRC_HDR_EN
                    state_d   = StHdr;
`else
                    state_d   = StPass;
`endif
                end
            end
`ifdef UART_ARB_SRC_HDR_EN
            StHdr: begin
                axis.m_tvalid_o = 1'b1;
                axis.m_tdata_o  = 8'hA0 | 8'(gidx_q);
                if (axis.m_tready_i) begin
                    state_d = StPass;
                end
            end
`endif
            StPass: begin
                axis.m_tdata_o  = g_tdata;
                axis.m_tvalid_o = g_tvalid;
                axis.s_tready_o = grant_q & {N_SRC{axis.m_tready_i}};
                beat            = g_tvalid & axis.m_tready_i;
                if (beat) begin
                    // A capped release leaves the rest of the packet queued at the source.
                    if (g_tlast || (beat_ct_q == LastBeat)) begin
                        state_d  = StIdle;
                        grant_d  = '0;
                        rr_ptr_d = gidx_q;
                    end else begin
                        beat_ct_d = beat_ct_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gidx_q    <= '0;
            rr_ptr_q  <= LastIdx;
            grant_q   <= '0;
            beat_ct_q <= '0;
        end else begin
            state_q   <= state_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            beat_ct_q <= beat_ct_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != StIdle);

endmodule
